// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer with one-shot/periodic modes and maskable interrupt
module bus_timer #(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_nx;
    logic [3:0]  ctrl, ctrl_nx;
    logic [31:0] preset, preset_nx, count, count_nx;
    logic        flag, flag_nx;
    logic        wr, ctrl_wr, en, periodic;
    assign wr       = sel & we;
    assign ctrl_wr  = wr & (addr == 2'd0) & (|be);
    assign en       = ctrl[0];
    assign periodic = ctrl[2:1] == 2'b01;
    assign irq      = flag & ctrl[3];
    assign rd = addr == 2'd0 ? {28'd0, ctrl} :
                addr == 2'd1 ? preset :
                addr == 2'd2 ? count : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ctrl   <= 4'd0;
            preset <= RESET_PRESET;
            count  <= 32'd0;
            flag   <= 1'b0;
        end else begin
            state  <= state_nx;
            ctrl   <= ctrl_nx;
            preset <= preset_nx;
            count  <= count_nx;
            flag   <= flag_nx;
        end
    end
    always_comb begin
        state_nx  = state;
        ctrl_nx   = ctrl;
        preset_nx = preset;
        count_nx  = count;
        flag_nx   = ctrl_wr ? 1'b0 : flag;
        for (int i = 0; i < 4; i++)
            if (wr && addr == 2'd1 && be[i]) preset_nx[8*i +: 8] = wd[8*i +: 8];
        case (state)
            IDLE: state_nx = en ? LOAD : IDLE;
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!en) state_nx = IDLE;
                else if (count > 32'd1) count_nx = count - 32'd1;
                else begin
                    count_nx = 32'd0;
                    flag_nx  = 1'b1;
                    state_nx = INT;
                end
            end
            default: begin
                state_nx = IDLE;
                if (periodic) flag_nx = 1'b0;
                else ctrl_nx[0] = 1'b0;
            end
        endcase
        // the CPU's CTRL write lands last so it overrides the one-shot EN clear
        if (wr && addr == 2'd0 && be[0]) ctrl_nx = wd[3:0];
    end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed scoreboard bench for bus_timer
module tb_bus_timer;
    localparam logic [31:0] RP = 32'h1234_5678;
    logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        irq;
    int          checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    bus_timer #(.RESET_PRESET(RP)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
        .be(be), .wd(wd), .rd(rd), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic pop_cmp(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic chk_rd(input logic [1:0] a, input logic [31:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        addr = a;
        #1;
        pop_cmp(rd);
    endtask

    task automatic chk_irq(input logic e, input string t);
        exp_q.push_back({31'd0, e});
        tag_q.push_back(t);
        #1;
        pop_cmp({31'd0, irq});
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wd = d; be = b;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; be = 4'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_rd(0, 32'd0, "reset ctrl");
        chk_rd(1, RP, "reset preset");
        chk_rd(2, 32'd0, "reset count");
        chk_rd(3, 32'd0, "reset off3");
        chk_irq(1'b0, "reset irq");

        // one-shot, PRESET=5
        bus_wr(1, 32'd5, 4'hF);
        bus_wr(0, 32'h9, 4'hF);
        step(); step();
        chk_rd(2, 32'd5, "oneshot count 5");
        chk_irq(1'b0, "oneshot irq low 5");
        for (int i = 4; i >= 1; i--) begin
            step();
            chk_rd(2, i, $sformatf("oneshot count %0d", i));
            chk_irq(1'b0, $sformatf("oneshot irq low %0d", i));
        end
        step();
        chk_rd(2, 32'd0, "oneshot count 0");
        chk_irq(1'b1, "oneshot irq rise");
        step();
        chk_rd(0, 32'h8, "oneshot en cleared");
        chk_irq(1'b1, "oneshot irq hold");
        step(); step();
        chk_irq(1'b1, "oneshot irq still held");
        bus_wr(0, 32'd0, 4'hF);
        chk_irq(1'b0, "oneshot irq cleared by ctrl write");

        // periodic, PRESET=3: LOAD,CNT x3,INT,IDLE repeating
        bus_wr(1, 32'd3, 4'hF);
        bus_wr(0, 32'hB, 4'hF);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk_irq(k % 6 == 5, $sformatf("periodic irq k=%0d", k));
        end
        chk_rd(0, 32'hB, "periodic en stays");
        bus_wr(0, 32'd0, 4'hF);
        step(); step();
        chk_rd(2, 32'd3, "periodic stop count holds");

        // byte enables and read-only/unused offsets
        bus_wr(1, 32'h1122_3344, 4'hF);
        bus_wr(1, 32'hAABB_CCDD, 4'b0101);
        chk_rd(1, 32'h11BB_33DD, "preset byte enables");
        bus_wr(1, 32'hFFFF_FFFF, 4'b0000);
        chk_rd(1, 32'h11BB_33DD, "preset be zero noop");
        bus_wr(2, 32'hFFFF_FFFF, 4'hF);
        chk_rd(2, 32'd3, "count write ignored");
        bus_wr(0, 32'hFFFF_FFF0, 4'hF);
        chk_rd(0, 32'd0, "ctrl upper bits ignored");
        bus_wr(3, 32'hFFFF_FFFF, 4'hF);
        chk_rd(3, 32'd0, "offset3 reads zero");

        // mid-count disable, then re-enable reloads
        bus_wr(1, 32'd6, 4'hF);
        bus_wr(0, 32'h9, 4'hF);
        repeat (5) step();
        chk_rd(2, 32'd3, "midcount count 3");
        bus_wr(0, 32'd0, 4'hF);
        chk_rd(2, 32'd2, "midcount last decrement");
        step(); step();
        chk_rd(2, 32'd2, "midcount count holds");
        chk_irq(1'b0, "midcount no irq");
        bus_wr(0, 32'h9, 4'hF);
        step(); step();
        chk_rd(2, 32'd6, "reenable reload");
        bus_wr(0, 32'd0, 4'hF);
        step(); step();

        // masked interrupt
        bus_wr(1, 32'd2, 4'hF);
        bus_wr(0, 32'h1, 4'hF);
        repeat (4) step();
        chk_rd(2, 32'd0, "masked count expired");
        chk_irq(1'b0, "masked irq low");
        step();
        chk_rd(0, 32'd0, "masked en cleared");
        bus_wr(0, 32'h8, 4'hF);
        chk_irq(1'b0, "masked flag cleared on im set");
        step();
        chk_irq(1'b0, "masked irq stays low");

        // reset while counting
        bus_wr(1, 32'd10, 4'hF);
        bus_wr(0, 32'h9, 4'hF);
        repeat (3) step();
        chk_rd(2, 32'd9, "precount before reset");
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_rd(0, 32'd0, "cnt reset ctrl");
        chk_rd(1, RP, "cnt reset preset");
        chk_rd(2, 32'd0, "cnt reset count");
        chk_irq(1'b0, "cnt reset irq");
        @(negedge clk);
        reset = 1'b0;
        step(); step();
        chk_rd(2, 32'd0, "post reset idle count");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
